// File: rtl/operand_entry_pkg.sv
// Shared encodings for the operand-entry front end: FSM states, ALU operation codes
// and the operand/operation field widths.
package operand_entry_pkg;

   localparam int DATA_W = 3;
   localparam int SEL_W  = 2;

   typedef enum logic [1:0] {
      S_A     = 2'b00,
      S_B     = 2'b01,
      S_OP    = 2'b10,
      S_ISSUE = 2'b11
   } state_t;

   typedef enum logic [SEL_W-1:0] {
      SEL_ADD = 2'b00,
      SEL_SUB = 2'b01,
      SEL_MUL = 2'b10,
      SEL_REM = 2'b11
   } sel_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-count debouncer and a registered
// one-cycle pulse on each accepted 0->1 transition of the debounced level.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             level;
   logic             level_q;
   logic [CNT_W-1:0] cnt;

   // The counter only advances while the synchronized input disagrees with the
   // accepted level; the last disagreeing sample flips the level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= 2'b00;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
         press   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], btn};
         level_q <= level;
         press   <= level & ~level_q;
         if (sync_q[1] != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync_q[1];
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/operand_entry.sv
// Operand entry FSM: collects two operands and an operation code from switches on
// debounced Enter presses, then presents them to the ALU under a valid/ready handshake.
module operand_entry
   import operand_entry_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] dataSw,
   input  logic [SEL_W-1:0]  opSw,
   input  logic              btnEnter,
   input  logic              btnClear,
   input  logic              opReady,
   output logic [DATA_W-1:0] num1,
   output logic [DATA_W-1:0] num2,
   output logic [SEL_W-1:0]  sel,
   output logic              opValid,
   output logic [1:0]        stage
);

   state_t state;
   logic   enter_pulse;
   logic   clear_pulse;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btnEnter),
      .press (enter_pulse)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btnClear),
      .press (clear_pulse)
   );

   // Clear takes priority over everything, including a handshake completing in
   // S_ISSUE: both end in S_A, so the handshake still counts as done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_A;
         num1    <= '0;
         num2    <= '0;
         sel     <= SEL_ADD;
         opValid <= 1'b0;
      end else if (clear_pulse) begin
         state   <= S_A;
         num1    <= '0;
         num2    <= '0;
         sel     <= SEL_ADD;
         opValid <= 1'b0;
      end else begin
         case (state)
            S_A: if (enter_pulse) begin
               num1  <= dataSw;
               state <= S_B;
            end
            S_B: if (enter_pulse) begin
               num2  <= dataSw;
               state <= S_OP;
            end
            S_OP: if (enter_pulse) begin
               sel     <= opSw;
               state   <= S_ISSUE;
               opValid <= 1'b1;
            end
            S_ISSUE: if (opReady) begin
               state   <= S_A;
               opValid <= 1'b0;
            end
            default: begin
               state   <= S_A;
               opValid <= 1'b0;
            end
         endcase
      end
   end

   assign stage = state;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a short debounce window; issued operations
// are predicted into a queue and compared when the ALU handshake fires.
module tb_operand_entry;

   localparam int DEB = 4;

   typedef struct packed {
      logic [2:0] n1;
      logic [2:0] n2;
      logic [1:0] s;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] dataSw;
   logic [1:0] opSw;
   logic       btnEnter;
   logic       btnClear;
   logic       opReady;
   logic [2:0] num1;
   logic [2:0] num2;
   logic [1:0] sel;
   logic       opValid;
   logic [1:0] stage;

   exp_t sb[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   ov_cycles = 0;
   int   handshakes = 0;

   operand_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .dataSw   (dataSw),
      .opSw     (opSw),
      .btnEnter (btnEnter),
      .btnClear (btnClear),
      .opReady  (opReady),
      .num1     (num1),
      .num2     (num2),
      .sel      (sel),
      .opValid  (opValid),
      .stage    (stage)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [2:0] d, input logic [1:0] o);
      dataSw   = d;
      opSw     = o;
      btnEnter = 1'b1;
      repeat (10) step();
      btnEnter = 1'b0;
      repeat (10) step();
   endtask

   // Scoreboard side: a handshake is sampled mid-cycle, before the accepting edge.
   always @(negedge clk) begin
      if (rst_n && opValid) ov_cycles++;
      if (rst_n && opValid && opReady) begin
         handshakes++;
         check("sb_pending", 8'(sb.size()), 8'd1);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("hs_num1", 8'(num1), 8'(e.n1));
            check("hs_num2", 8'(num2), 8'(e.n2));
            check("hs_sel",  8'(sel),  8'(e.s));
         end
      end
   end

   initial begin
      int bad;
      rst_n = 1'b0; dataSw = '0; opSw = '0;
      btnEnter = 1'b0; btnClear = 1'b0; opReady = 1'b0;
      repeat (3) step();
      check("rst_stage", 8'(stage), 8'd0);
      check("rst_valid", 8'(opValid), 8'd0);
      check("rst_num1", 8'(num1), 8'd0);
      check("rst_num2", 8'(num2), 8'd0);
      check("rst_sel", 8'(sel), 8'd0);
      rst_n = 1'b1;
      repeat (3) step();

      // Basic entry with the ALU always ready
      press(3'd5, 2'b00);
      check("a_stage", 8'(stage), 8'd1);
      check("a_num1", 8'(num1), 8'd5);
      press(3'd2, 2'b00);
      check("b_stage", 8'(stage), 8'd2);
      check("b_num2", 8'(num2), 8'd2);
      opReady = 1'b1;
      sb.push_back('{n1: 3'd5, n2: 3'd2, s: 2'b11});
      ov_cycles = 0;
      press(3'd0, 2'b11);
      check("issue_one_cycle", 8'(ov_cycles), 8'd1);
      check("issue_back_to_a", 8'(stage), 8'd0);
      check("issue_valid_low", 8'(opValid), 8'd0);
      opReady = 1'b0;

      // Bouncing Enter, then a solid press
      dataSw = 3'd6;
      for (int i = 0; i < 10; i++) begin
         btnEnter = ~btnEnter;
         step();
         step();
      end
      check("bounce_no_update", 8'(stage), 8'd0);
      btnEnter = 1'b1;
      repeat (12) step();
      check("bounce_stage", 8'(stage), 8'd1);
      check("bounce_num1", 8'(num1), 8'd6);
      repeat (10) step();
      check("bounce_single", 8'(stage), 8'd1);
      btnEnter = 1'b0;
      repeat (10) step();

      // Stall in S_ISSUE, Enter ignored there
      press(3'd1, 2'b00);
      sb.push_back('{n1: 3'd6, n2: 3'd1, s: 2'b10});
      press(3'd0, 2'b10);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (opValid !== 1'b1 || num1 !== 3'd6 || num2 !== 3'd1 || sel !== 2'b10 || stage !== 2'd3)
            bad++;
      end
      check("stall_stable", 8'(bad), 8'd0);
      press(3'd7, 2'b01);
      check("issue_enter_ign_stage", 8'(stage), 8'd3);
      check("issue_enter_ign_num1", 8'(num1), 8'd6);
      check("issue_enter_ign_sel", 8'(sel), 8'd2);
      opReady = 1'b1;
      step();
      check("stall_release_valid", 8'(opValid), 8'd0);
      check("stall_release_stage", 8'(stage), 8'd0);
      opReady = 1'b0;

      // Enter and Clear together in S_OP
      press(3'd3, 2'b00);
      press(3'd4, 2'b00);
      check("op_stage", 8'(stage), 8'd2);
      btnEnter = 1'b1;
      btnClear = 1'b1;
      repeat (10) step();
      btnEnter = 1'b0;
      btnClear = 1'b0;
      repeat (10) step();
      check("clr_stage", 8'(stage), 8'd0);
      check("clr_num1", 8'(num1), 8'd0);
      check("clr_num2", 8'(num2), 8'd0);
      check("clr_sel", 8'(sel), 8'd0);

      // Clear landing on the same edge as an accepted handshake
      press(3'd2, 2'b00);
      press(3'd3, 2'b00);
      sb.push_back('{n1: 3'd2, n2: 3'd3, s: 2'b01});
      press(3'd0, 2'b01);
      check("clrhs_in_issue", 8'(stage), 8'd3);
      btnClear = 1'b1;
      repeat (7) step();
      check("clrhs_not_yet", 8'(stage), 8'd3);
      opReady = 1'b1;
      step();
      check("clrhs_stage", 8'(stage), 8'd0);
      check("clrhs_valid", 8'(opValid), 8'd0);
      check("clrhs_num1", 8'(num1), 8'd0);
      check("clrhs_sel", 8'(sel), 8'd0);
      opReady = 1'b0;
      btnClear = 1'b0;
      repeat (10) step();

      // Asynchronous reset while issuing, with Enter held through release
      press(3'd1, 2'b00);
      press(3'd2, 2'b00);
      sb.push_back('{n1: 3'd1, n2: 3'd2, s: 2'b01});
      press(3'd0, 2'b01);
      check("pre_rst_valid", 8'(opValid), 8'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      btnEnter = 1'b1;
      #1;
      check("async_rst_valid", 8'(opValid), 8'd0);
      check("async_rst_stage", 8'(stage), 8'd0);
      check("async_rst_num1", 8'(num1), 8'd0);
      sb.delete();
      step();
      step();
      dataSw = 3'd4;
      rst_n = 1'b1;
      repeat (7) step();
      check("held_no_early", 8'(stage), 8'd0);
      step();
      check("held_stage", 8'(stage), 8'd1);
      check("held_num1", 8'(num1), 8'd4);
      repeat (20) step();
      check("held_single", 8'(stage), 8'd1);
      btnEnter = 1'b0;
      repeat (10) step();

      // Finish the sequence started after reset
      press(3'd5, 2'b00);
      sb.push_back('{n1: 3'd4, n2: 3'd5, s: 2'b10});
      opReady = 1'b1;
      press(3'd0, 2'b10);
      check("final_stage", 8'(stage), 8'd0);
      check("final_valid", 8'(opValid), 8'd0);
      opReady = 1'b0;
      repeat (5) step();

      check("sb_drained", 8'(sb.size()), 8'd0);
      check("handshake_count", 8'(handshakes), 8'd4);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
